// File: rtl/note_lane_engine.sv
// note_lane_engine: multi-lane note scroller with per-lane hit judging,
// combo tracking and a saturating score, fed by a chart-row handshake.

module note_lane_judge #(
    parameter int DEPTH = 10,
    parameter int WIN   = 2
) (
    input  logic [DEPTH-1:0] cells,
    input  logic             press,
    input  logic             step_en,
    input  logic             entry,
    output logic [DEPTH-1:0] cells_next,
    output logic             hit_p,
    output logic             hit_g,
    output logic             ghost,
    output logic             miss
);
    logic [DEPTH-1:0] kept;
    logic             found;

    always_comb begin
        kept  = cells;
        found = 1'b0;
        hit_p = 1'b0;
        hit_g = 1'b0;
        if (press) begin
            for (int i = 0; i < WIN; i++) begin
                if (!found && cells[i]) begin
                    found   = 1'b1;
                    kept[i] = 1'b0;
                    hit_p   = (i == 0);
                    hit_g   = (i != 0);
                end
            end
        end
        ghost = press && !found;
        // the judged cell is removed before scrolling, so a hit at index 0 is never a miss
        miss       = step_en && kept[0];
        cells_next = step_en ? ((kept >> 1) | (DEPTH'(entry) << (DEPTH - 1))) : kept;
    end
endmodule

module note_lane_engine #(
    parameter int N_LANES      = 2,
    parameter int DEPTH        = 10,
    parameter int WIN          = 2,
    parameter int SCORE_W      = 16,
    parameter int COMBO_W      = 8,
    parameter int PERFECT_PTS  = 2,
    parameter int GOOD_PTS     = 1,
    parameter int GHOST_BREAKS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       step,
    input  logic                       chart_valid,
    output logic                       chart_ready,
    input  logic [N_LANES-1:0]         chart_notes,
    input  logic                       chart_last,
    input  logic [N_LANES-1:0]         btn,
    output logic [N_LANES*DEPTH-1:0]   lanes,
    output logic [SCORE_W-1:0]         score,
    output logic [COMBO_W-1:0]         combo,
    output logic [COMBO_W-1:0]         max_combo,
    output logic [N_LANES-1:0]         hit_perfect,
    output logic [N_LANES-1:0]         hit_good,
    output logic                       miss,
    output logic                       busy,
    output logic                       finish
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN, S_DONE} state_t;

    localparam int PW = SCORE_W + 8;
    localparam int CW = COMBO_W + 4;

    state_t                        state, state_nx;
    logic [N_LANES-1:0][DEPTH-1:0] cell_q, cell_nx;
    logic [N_LANES-1:0]            btn_q, press, hp, hg, gh, ms;
    logic                          active, step_en, accept, song_start, breaks;
    logic [1:0]                    mult;
    logic [3:0]                    nhits;
    logic [PW-1:0]                 add_pts, score_sum;
    logic [CW-1:0]                 combo_sum;
    logic [SCORE_W-1:0]            score_nx;
    logic [COMBO_W-1:0]            combo_nx, max_nx;

    assign active      = (state == S_PLAY) || (state == S_DRAIN);
    assign step_en     = active && step;
    assign chart_ready = (state == S_PLAY) && step;
    assign accept      = chart_valid && chart_ready;
    assign song_start  = start && ((state == S_IDLE) || (state == S_DONE));
    assign press       = (btn & ~btn_q) & {N_LANES{active}};
    assign busy        = active;
    assign finish      = (state == S_DONE);
    assign lanes       = cell_q;

    generate
        for (genvar l = 0; l < N_LANES; l++) begin : g_lane
            note_lane_judge #(
                .DEPTH (DEPTH),
                .WIN   (WIN)
            ) u_lane (
                .cells      (cell_q[l]),
                .press      (press[l]),
                .step_en    (step_en),
                .entry      (accept && chart_notes[l]),
                .cells_next (cell_nx[l]),
                .hit_p      (hp[l]),
                .hit_g      (hg[l]),
                .ghost      (gh[l]),
                .miss       (ms[l])
            );
        end
    endgenerate

    // multiplier is chosen from the combo held before this cycle's hits land
    always_comb begin
        if (32'(combo) >= 32'd32)      mult = 2'd2;
        else if (32'(combo) >= 32'd16) mult = 2'd1;
        else                           mult = 2'd0;
        add_pts = '0;
        nhits   = '0;
        for (int l = 0; l < N_LANES; l++) begin
            if (hp[l]) add_pts = add_pts + (PW'(PERFECT_PTS) << mult);
            if (hg[l]) add_pts = add_pts + (PW'(GOOD_PTS) << mult);
            nhits = nhits + {3'b000, hp[l] | hg[l]};
        end
        score_sum = PW'(score) + add_pts;
        score_nx  = (score_sum > PW'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
        combo_sum = CW'(combo) + CW'(nhits);
        breaks    = (|ms) || ((GHOST_BREAKS != 0) && (|gh));
        if (breaks)                                 combo_nx = '0;
        else if (combo_sum > CW'({COMBO_W{1'b1}})) combo_nx = '1;
        else                                        combo_nx = combo_sum[COMBO_W-1:0];
        max_nx = (combo_nx > max_combo) ? combo_nx : max_combo;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_PLAY;
            S_PLAY:  if (accept && chart_last) state_nx = S_DRAIN;
            S_DRAIN: if (cell_nx == '0) state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_PLAY;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_q      <= '0;
            btn_q       <= '0;
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
            hit_perfect <= '0;
            hit_good    <= '0;
            miss        <= 1'b0;
        end else begin
            btn_q <= btn;
            if (song_start) begin
                cell_q      <= '0;
                score       <= '0;
                combo       <= '0;
                max_combo   <= '0;
                hit_perfect <= '0;
                hit_good    <= '0;
                miss        <= 1'b0;
            end else if (active) begin
                cell_q      <= cell_nx;
                score       <= score_nx;
                combo       <= combo_nx;
                max_combo   <= max_nx;
                hit_perfect <= hp;
                hit_good    <= hg;
                miss        <= |ms;
            end else begin
                hit_perfect <= '0;
                hit_good    <= '0;
                miss        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_note_lane_engine.sv
// Scoreboard bench for note_lane_engine: a queue-of-positions note model
// predicts every cycle's outputs; a monitor pops and compares after each edge.
module tb_note_lane_engine;
    localparam int NL = 2, DP = 10, WN = 2, SW = 12, CWD = 8, PP = 2, GP = 1;
    localparam int SMAX = (1 << SW) - 1, CMAX = (1 << CWD) - 1;
    localparam int M_IDLE = 0, M_PLAY = 1, M_DRAIN = 2, M_DONE = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1, start = 1'b0, step = 1'b0, chart_valid = 1'b0, chart_last = 1'b0;
    logic              chart_ready;
    logic [NL-1:0]     chart_notes = '0, btn = '0;
    logic [NL*DP-1:0]  lanes;
    logic [SW-1:0]     score;
    logic [CWD-1:0]    combo, max_combo;
    logic [NL-1:0]     hit_perfect, hit_good;
    logic              miss, busy, finish;

    always #5 clk = ~clk;

    note_lane_engine #(
        .N_LANES(NL), .DEPTH(DP), .WIN(WN), .SCORE_W(SW), .COMBO_W(CWD),
        .PERFECT_PTS(PP), .GOOD_PTS(GP), .GHOST_BREAKS(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .chart_valid(chart_valid), .chart_ready(chart_ready),
        .chart_notes(chart_notes), .chart_last(chart_last), .btn(btn),
        .lanes(lanes), .score(score), .combo(combo), .max_combo(max_combo),
        .hit_perfect(hit_perfect), .hit_good(hit_good), .miss(miss),
        .busy(busy), .finish(finish)
    );

    typedef struct packed {
        logic [NL*DP-1:0] lanes;
        logic [SW-1:0]    score;
        logic [CWD-1:0]   combo;
        logic [CWD-1:0]   max_combo;
        logic [NL-1:0]    hp;
        logic [NL-1:0]    hg;
        logic             miss;
        logic             busy;
        logic             finish;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_chk = 0, n_fail = 0;

    // model: each lane is a sorted list of note positions (0 = judge line)
    int            q[NL][$];
    int            m_state = M_IDLE, m_score = 0, m_combo = 0, m_max = 0;
    logic [NL-1:0] m_btnq = '0;
    logic          m_acc = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_song();
        for (int l = 0; l < NL; l++) q[l].delete();
        m_score = 0; m_combo = 0; m_max = 0;
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic cv,
                         input logic [NL-1:0] cn, input logic cl, input logic [NL-1:0] b);
        exp_t          e;
        logic          exp_rdy, gh, ms, empty;
        logic [NL-1:0] pr;
        int            pts, hits, mul;
        @(negedge clk);
        rst = r; start = s; step = st; chart_valid = cv; chart_notes = cn; chart_last = cl; btn = b;
        exp_rdy = (m_state == M_PLAY) && st;
        m_acc = exp_rdy && cv && !r;
        e = '0; gh = 1'b0; ms = 1'b0; pts = 0; hits = 0;
        if (r) begin
            clear_song();
            m_state = M_IDLE;
            m_btnq = '0;
        end else begin
            pr = b & ~m_btnq;
            m_btnq = b;
            if ((m_state == M_IDLE || m_state == M_DONE) && s) begin
                clear_song();
                m_state = M_PLAY;
            end else if (m_state == M_PLAY || m_state == M_DRAIN) begin
                mul = (m_combo >= 32) ? 4 : (m_combo >= 16) ? 2 : 1;
                for (int l = 0; l < NL; l++) begin
                    if (pr[l]) begin
                        if (q[l].size() > 0 && q[l][0] < WN) begin
                            if (q[l][0] == 0) begin e.hp[l] = 1'b1; pts += PP * mul; end
                            else              begin e.hg[l] = 1'b1; pts += GP * mul; end
                            hits++;
                            void'(q[l].pop_front());
                        end else gh = 1'b1;
                    end
                end
                if (st) begin
                    for (int l = 0; l < NL; l++) begin
                        for (int k = 0; k < q[l].size(); k++) q[l][k] = q[l][k] - 1;
                        if (q[l].size() > 0 && q[l][0] < 0) begin ms = 1'b1; void'(q[l].pop_front()); end
                        if (m_acc && cn[l]) q[l].push_back(DP - 1);
                    end
                end
                m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
                if (ms || gh) m_combo = 0;
                else          m_combo = (m_combo + hits > CMAX) ? CMAX : m_combo + hits;
                if (m_combo > m_max) m_max = m_combo;
                empty = 1'b1;
                for (int l = 0; l < NL; l++) if (q[l].size() != 0) empty = 1'b0;
                if (m_state == M_PLAY && m_acc && cl) m_state = M_DRAIN;
                else if (m_state == M_DRAIN && empty) m_state = M_DONE;
            end
        end
        for (int l = 0; l < NL; l++)
            for (int k = 0; k < q[l].size(); k++) e.lanes[l*DP + q[l][k]] = 1'b1;
        e.score     = SW'(m_score);
        e.combo     = CWD'(m_combo);
        e.max_combo = CWD'(m_max);
        e.miss      = ms;
        e.busy      = (m_state == M_PLAY) || (m_state == M_DRAIN);
        e.finish    = (m_state == M_DONE);
        sb.push_back(e);
        #1 chk("chart_ready", 64'(chart_ready), 64'(exp_rdy));
    endtask

    // mode 0: random play, mode 1: perfect player on a full chart, mode 2: quick single-lane rows
    task automatic song(input int rows, input int mode, input int rst_at);
        int            sent, cyc;
        logic          r, s, st, cv, cl;
        logic [NL-1:0] cn, b;
        sent = 0; cyc = 0;
        drive(0, 1, 0, 0, '0, 0, '0);
        while (cyc < 20 * rows + 200 && m_state != M_DONE && m_state != M_IDLE) begin
            r = (cyc == rst_at) || (mode == 0 && $urandom_range(0, 399) == 0);
            s = (mode == 0) && ($urandom_range(0, 19) == 0);
            cl = (sent == rows - 1);
            b = '0;
            case (mode)
                1: begin
                    st = (cyc % 2 == 0); cv = 1'b1; cn = '1;
                    for (int l = 0; l < NL; l++)
                        b[l] = (q[l].size() > 0) && (q[l][0] == 0) && !m_btnq[l];
                end
                2: begin st = 1'b1; cv = 1'b1; cn = NL'(1); end
                default: begin
                    st = 1'($urandom_range(0, 1));
                    cv = ($urandom_range(0, 3) != 0);
                    cn = NL'($urandom);
                    if ($urandom_range(0, 2) == 0) b = NL'($urandom);
                end
            endcase
            drive(r, s, st, cv, cn, cl, b);
            if (m_acc) sent++;
            cyc++;
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk("lanes",       64'(lanes),       64'(me.lanes));
                chk("score",       64'(score),       64'(me.score));
                chk("combo",       64'(combo),       64'(me.combo));
                chk("max_combo",   64'(max_combo),   64'(me.max_combo));
                chk("hit_perfect", 64'(hit_perfect), 64'(me.hp));
                chk("hit_good",    64'(hit_good),    64'(me.hg));
                chk("miss",        64'(miss),        64'(me.miss));
                chk("busy",        64'(busy),        64'(me.busy));
                chk("finish",      64'(finish),      64'(me.finish));
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, '0, 0, '0);
        drive(1, 1, 1, 1, '1, 1, '1);
        drive(0, 0, 1, 1, '1, 0, '0);
        drive(0, 0, 0, 0, '0, 0, '1);
        song(3, 2, 6);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, '1, 0, '0);
        song(400, 1, -1);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, '1, 0, NL'(i));
        for (int n = 0; n < 8; n++) begin
            song(20 + n * 4, 0, -1);
            drive(0, 0, 1, 0, '0, 0, '0);
        end
        song(3, 2, -1);
        drive(0, 0, 0, 0, '0, 0, '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
